// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the pad clock/data, deframes 11-bit
// frames and folds E0/F0 prefixes into one decoded key event.
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_valid,
  output logic [7:0] o_scancode,
  output logic       o_extended,
  output logic       o_break,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s2_q, clk_s3_q;
  logic        dat_s1_q, dat_s2_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic        valid_q, valid_d;
  logic [7:0]  scancode_q, scancode_d;
  logic        out_ext_q, out_ext_d;
  logic        out_brk_q, out_brk_d;
  logic        frame_err_q, frame_err_d;
  logic        fall_s;
  logic        data_s;

  assign fall_s = clk_s3_q & ~clk_s2_q;
  assign data_s = dat_s2_q;

  // Next-state, deframing, prefix tracking and timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    valid_d     = 1'b0;
    scancode_d  = scancode_q;
    out_ext_d   = out_ext_q;
    out_brk_d   = out_brk_q;
    frame_err_d = 1'b0;
    // An edge outranks a timeout expiring in the same cycle.
    if (fall_s) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && odd_parity_ok(shift_q, parity_q)) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              valid_d    = 1'b1;
              scancode_d = shift_q;
              out_ext_d  = ext_q;
              out_brk_d  = brk_q;
              ext_d      = 1'b0;
              brk_d      = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TO_MAX) begin
        state_d = IDLE;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + CW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Synchronizers, FSM state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_s3_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      valid_q     <= 1'b0;
      scancode_q  <= 8'h00;
      out_ext_q   <= 1'b0;
      out_brk_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= i_ps2_clk;
      clk_s2_q    <= clk_s1_q;
      clk_s3_q    <= clk_s2_q;
      dat_s1_q    <= i_ps2_data;
      dat_s2_q    <= dat_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      valid_q     <= valid_d;
      scancode_q  <= scancode_d;
      out_ext_q   <= out_ext_d;
      out_brk_q   <= out_brk_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_scancode  = scancode_q;
  assign o_extended  = out_ext_q;
  assign o_break     = out_brk_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != IDLE);

endmodule
